// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic                  cin;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  cout;
    logic                  neg;
    logic                  err;

    // Requester side: drives operands and start, observes status and result.
    modport master (
        output start, sub, cin, a, b,
        input  busy, done, result, cout, neg, err
    );

    // Arithmetic unit side.
    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, result, cout, neg, err
    );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Subtraction uses nine's complement plus an injected carry; a borrow-out result
// is converted to sign-magnitude by a second digit-serial ten's-complement pass.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_addsub_if.slave   bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;

    // Flag every incoming nibble that is not a decimal digit.
    logic [2*DIGITS-1:0] digit_bad;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
        assign digit_bad[gi]          = (bus.a[4*gi +: 4] > 4'd9);
        assign digit_bad[DIGITS + gi] = (bus.b[4*gi +: 4] > 4'd9);
    end

    // Shared single-digit decimal adder used by both the ADD and FIX passes.
    logic [IDX_W+1:0] bit_base;
    logic [3:0]       op_x;
    logic [3:0]       op_y;
    logic [4:0]       raw_sum;
    logic [3:0]       sum_digit;
    logic             sum_carry;

    always_comb begin
        bit_base = {idx_q, 2'b00};
        op_x     = a_q[bit_base +: 4];
        op_y     = sub_q ? (4'd9 - b_q[bit_base +: 4]) : b_q[bit_base +: 4];
        if (state_q == S_FIX) begin
            // Ten's complement of the stored digit: (9 - r) plus the running carry.
            op_x = 4'd9 - result_q[bit_base +: 4];
            op_y = 4'd0;
        end
        raw_sum = {1'b0, op_x} + {1'b0, op_y} + {4'd0, carry_q};
        if (raw_sum > 5'd9) begin
            sum_digit = 4'(raw_sum - 5'd10);
            sum_carry = 1'b1;
        end else begin
            sum_digit = raw_sum[3:0];
            sum_carry = 1'b0;
        end
    end

    // Next-state and datapath update for the accept / add / fix / done sequence.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        neg_d    = neg_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    sub_d    = bus.sub;
                    carry_d  = bus.sub ? 1'b1 : bus.cin;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    neg_d    = 1'b0;
                    err_d    = 1'b0;
                    if (|digit_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                result_d[bit_base +: 4] = sum_digit;
                carry_d = sum_carry;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (!sub_q) begin
                        cout_d  = sum_carry;
                        state_d = S_DONE;
                    end else if (sum_carry) begin
                        state_d = S_DONE;
                    end else begin
                        // Borrow out: A < B, magnitude recovered in the FIX pass.
                        neg_d   = 1'b1;
                        carry_d = 1'b1;
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                result_d[bit_base +: 4] = sum_digit;
                carry_d = sum_carry;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.neg    = neg_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4): directed vector table,
// randomized operations against an integer-arithmetic model, and control corner cases.
module tb_bcd_serial_addsub;
    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;

    bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] r;
        logic        co;
        logic        ng;
        logic        er;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on decoded decimal values.
    function automatic int bcd2int(input logic [15:0] v);
        int s;
        s = 0;
        for (int i = DIGITS - 1; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
        return s;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int          m;
        m = n;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [15:0] v);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                         input logic mc, output vec_t v);
        int x, y, s;
        v.a = ma; v.b = mb; v.sub = ms; v.cin = mc;
        v.r = '0; v.co = 1'b0; v.ng = 1'b0; v.er = 1'b0;
        if (has_bad(ma) || has_bad(mb)) begin
            v.er  = 1'b1;
            v.lat = 0;
        end else begin
            x = bcd2int(ma);
            y = bcd2int(mb);
            if (!ms) begin
                s     = x + y + int'(mc);
                v.r   = int2bcd(s % 10000);
                v.co  = (s >= 10000);
                v.lat = DIGITS;
            end else if (x >= y) begin
                v.r   = int2bcd(x - y);
                v.lat = DIGITS;
            end else begin
                v.r   = int2bcd(y - x);
                v.ng  = 1'b1;
                v.lat = 2 * DIGITS;
            end
        end
    endtask

    // Launch one operation, count edges after the accept edge until done, then
    // confirm the unit returns to idle one cycle later.
    task automatic run_and_check(input vec_t v, input string tag);
        int   lat;
        logic busy0;
        @(negedge clk);
        bus.a = v.a; bus.b = v.b; bus.sub = v.sub; bus.cin = v.cin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy0 = bus.busy;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) lat = -1;
        $display("[TB] %s a=%h b=%h sub=%0d cin=%0d -> result=%h cout=%0d neg=%0d err=%0d lat=%0d",
                 tag, v.a, v.b, v.sub, v.cin, bus.result, bus.cout, bus.neg, bus.err, lat);
        chk({tag, " busy"},   int'(busy0),      1);
        chk({tag, " result"}, int'(bus.result), int'(v.r));
        chk({tag, " cout"},   int'(bus.cout),   int'(v.co));
        chk({tag, " neg"},    int'(bus.neg),    int'(v.ng));
        chk({tag, " err"},    int'(bus.err),    int'(v.er));
        chk({tag, " latency"}, lat, v.lat);
        @(posedge clk); #1;
        chk({tag, " idle busy"}, int'(bus.busy), 0);
        chk({tag, " idle done"}, int'(bus.done), 0);
        chk({tag, " result held"}, int'(bus.result), int'(v.r));
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        int   lat;
        int   done_seen;
        logic [15:0] ra, rb;

        tests_run = 0;
        tests_failed = 0;

        vecs[0] = '{16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
        vecs[1] = '{16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 4};
        vecs[2] = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b0, 1'b0, 4};
        vecs[3] = '{16'h0042, 16'h0042, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4};
        vecs[4] = '{16'h1234, 16'h5000, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b1, 1'b0, 8};
        vecs[5] = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
        vecs[7] = '{16'h0100, 16'h0001, 1'b1, 1'b1, 16'h0099, 1'b0, 1'b0, 1'b0, 4};
        vecs[8] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 8};

        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",   int'(bus.busy),   0);
        chk("reset done",   int'(bus.done),   0);
        chk("reset result", int'(bus.result), 0);
        chk("reset flags",  int'({bus.cout, bus.neg, bus.err}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 9; i++) run_and_check(vecs[i], $sformatf("vec%0d", i));

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                            : 4'($urandom_range(0, 9));
                rb[4*d +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                            : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) rb = ra;
            model(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv);
            run_and_check(rv, $sformatf("rnd%0d", n));
        end

        // start pulsed mid-ADD with different operands must be ignored.
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.a = 16'h5555; bus.b = 16'h4444; bus.sub = 1'b1; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 2;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) lat = -1;
        $display("[TB] restart-mid-add result=%h cout=%0d neg=%0d lat=%0d",
                 bus.result, bus.cout, bus.neg, lat);
        chk("midstart result",  int'(bus.result), 16'h3333);
        chk("midstart flags",   int'({bus.cout, bus.neg, bus.err}), 0);
        chk("midstart latency", lat, 4);
        @(posedge clk); #1;
        chk("midstart idle", int'(bus.busy), 0);

        // Asynchronous reset for half a cycle at E2 abandons the operation.
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset partial result", int'(bus.result[3:0]), 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        $display("[TB] reset-at-E2 busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
        chk("midreset busy",   int'(bus.busy),   0);
        chk("midreset done",   int'(bus.done),   0);
        chk("midreset result", int'(bus.result), 0);
        chk("midreset flags",  int'({bus.cout, bus.neg, bus.err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_seen = 1;
        end
        chk("no done after reset", done_seen, 0);

        // A fresh operation after reset completes normally.
        model(16'h0458, 16'h0967, 1'b1, 1'b0, rv);
        run_and_check(rv, "post-reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
